// File: rtl/inv_sub_bytes_iter.sv
// Iterative AES inverse SubBytes stage.
// One 128-bit state is accepted through a valid/ready handshake, substituted
// in place BYTES_PER_CYCLE bytes per clock through a shared inverse S-box
// bank, and presented from the working register through a second handshake.
// Byte i of a state occupies bits [8i:8i+7]; byte 0 is bits 0:7.

module inv_sub_bytes_iter #(
   parameter int BYTES_PER_CYCLE = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         inValid,
   output logic         inReady,
   input  logic [0:127] stateIn,
   output logic         outValid,
   input  logic         outReady,
   output logic [0:127] stateOut,
   output logic         busy
);

   // Number of groups per state and the width of the group counter.
   localparam int N     = 16 / BYTES_PER_CYCLE;
   localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
   localparam logic [CNT_W-1:0] LAST_GRP = CNT_W'(N - 1);

   // Only widths that split the state into whole, equal groups are usable.
   if (BYTES_PER_CYCLE != 1 && BYTES_PER_CYCLE != 2 && BYTES_PER_CYCLE != 4 &&
       BYTES_PER_CYCLE != 8 && BYTES_PER_CYCLE != 16) begin : g_bad_bpc
      $error("inv_sub_bytes_iter: BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
   end

   // Inverse S-box table, row-major: entry x sits at bits [8x:8x+7].
   localparam logic [0:2047] INV_SBOX = {
      128'h52096ad53036a538bf40a39e81f3d7fb,
      128'h7ce339829b2fff87348e4344c4dee9cb,
      128'h547b9432a6c2233dee4c950b42fac34e,
      128'h082ea16628d924b2765ba2496d8bd125,
      128'h72f8f66486689816d4a45ccc5d65b692,
      128'h6c704850fdedb9da5e154657a78d9d84,
      128'h90d8ab008cbcd30af7e45805b8b34506,
      128'hd02c1e8fca3f0f02c1afbd0301138a6b,
      128'h3a9111414f67dcea97f2cfcef0b4e673,
      128'h96ac7422e7ad3585e2f937e81c75df6e,
      128'h47f11a711d29c5896fb7620eaa18be1b,
      128'hfc563e4bc6d279209adbc0fe78cd5af4,
      128'h1fdda8338807c731b11210592780ec5f,
      128'h60517fa919b54a0d2de57a9f93c99cef,
      128'ha0e03b4dae2af5b0c8ebbb3c83539961,
      128'h172b047eba77d626e169146355210c7d
   };

   // Combinational 256-entry inverse substitution.
   function automatic logic [7:0] inv_sbox(input logic [7:0] x);
      return INV_SBOX[{x, 3'b000} +: 8];
   endfunction

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t              state_q;
   logic [CNT_W-1:0]    grp_q;
   logic [0:127]        data_q;
   logic                out_valid_q;
   logic                busy_q;

   logic [0:8*BYTES_PER_CYCLE-1] lane_sub;
   logic [0:127]                 data_d;

   // S-box lanes: lane gi serves byte grp*BPC+gi of the working register.
   for (genvar gi = 0; gi < BYTES_PER_CYCLE; gi++) begin : g_lane
      logic [7:0] lane_byte;

      // Select the lane's byte from the group currently being processed.
      always_comb begin
         lane_byte = 8'h00;
         for (int g = 0; g < N; g++) begin
            if (grp_q == CNT_W'(g)) begin
               lane_byte = data_q[8*(g*BYTES_PER_CYCLE+gi) +: 8];
            end
         end
      end

      assign lane_sub[8*gi +: 8] = inv_sbox(lane_byte);
   end

   // Next working register: the active group takes the lane results, every
   // other byte keeps its value.
   for (genvar gi = 0; gi < 16; gi++) begin : g_byte
      localparam int GRP  = gi / BYTES_PER_CYCLE;
      localparam int LANE = gi % BYTES_PER_CYCLE;

      assign data_d[8*gi +: 8] = (grp_q == CNT_W'(GRP)) ? lane_sub[8*LANE +: 8]
                                                        : data_q[8*gi +: 8];
   end

   // A new state is taken when idle, or when the finished result is being
   // consumed on the same edge. Depends only on FSM state and outReady.
   assign inReady  = (state_q == ST_IDLE) | ((state_q == ST_DONE) & outReady);
   assign outValid = out_valid_q;
   assign busy     = busy_q;
   assign stateOut = data_q;

   // Control FSM and working register; reset clears everything.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         grp_q       <= '0;
         data_q      <= '0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (inValid) begin
                  data_q  <= stateIn;
                  grp_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= ST_RUN;
               end
            end

            ST_RUN: begin
               data_q <= data_d;
               grp_q  <= grp_q + 1'b1;
               if (grp_q == LAST_GRP) begin
                  out_valid_q <= 1'b1;
                  state_q     <= ST_DONE;
               end
            end

            ST_DONE: begin
               if (outReady) begin
                  out_valid_q <= 1'b0;
                  if (inValid) begin
                     data_q  <= stateIn;
                     grp_q   <= '0;
                     state_q <= ST_RUN;
                  end else begin
                     busy_q  <= 1'b0;
                     state_q <= ST_IDLE;
                  end
               end
            end

            default: begin
               out_valid_q <= 1'b0;
               busy_q      <= 1'b0;
               state_q     <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_inv_sub_bytes_iter.sv
// Bench for inv_sub_bytes_iter: five instances (BPC 1,2,4,8,16) share the
// same stimulus. A monitor keeps a per-instance expectation queue filled at
// each accept and checks handshakes, latency, data and reset behaviour.

module tb_inv_sub_bytes_iter;

   logic         clk = 1'b0;
   logic         reset;
   logic         in_valid;
   logic         out_ready;
   logic [0:127] state_in;

   logic         in_ready  [5];
   logic         out_valid [5];
   logic         busy_o    [5];
   logic [0:127] state_out [5];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   for (genvar gi = 0; gi < 5; gi++) begin : g_dut
      inv_sub_bytes_iter #(.BYTES_PER_CYCLE(1 << gi)) u_dut (
         .clk      (clk),
         .reset    (reset),
         .inValid  (in_valid),
         .inReady  (in_ready[gi]),
         .stateIn  (state_in),
         .outValid (out_valid[gi]),
         .outReady (out_ready),
         .stateOut (state_out[gi]),
         .busy     (busy_o[gi])
      );
   end

   // Reference inverse S-box, derived from GF(2^8) inversion and the affine map.
   logic [7:0] inv_tab [256];

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      logic       hi;
      for (int k = 0; k < 8; k++) begin
         if (b[0]) p = p ^ a;
         hi = a[7];
         a  = a << 1;
         if (hi) a = a ^ 8'h1b;
         b  = b >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
      return (v << n) | (v >> (8 - n));
   endfunction

   task automatic build_model();
      logic [7:0] b, s;
      for (int x = 0; x < 256; x++) begin
         b = 8'h00;
         for (int y = 1; y < 256; y++) begin
            if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) b = 8'(y);
         end
         s = b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
         inv_tab[s] = 8'(x);
      end
   endtask

   function automatic logic [0:127] ref_sub(input logic [0:127] s);
      logic [0:127] r;
      for (int b = 0; b < 16; b++) r[8*b +: 8] = inv_tab[s[8*b +: 8]];
      return r;
   endfunction

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Edge bookkeeping.
   int   cyc = 0;
   logic armed = 1'b0;
   logic rst_last = 1'b0;
   logic stream_mode = 1'b0;

   always @(posedge clk) begin
      cyc++;
      rst_last = reset;
      if (reset) armed = 1'b1;
   end

   // Scoreboard state per instance.
   logic [0:127] exp_q [5][$];
   int           acc_q [5][$];
   int           pops     [5];
   int           last_pop [5];
   logic [0:127] last_out [5];
   logic         stream_prev = 1'b0;

   initial begin
      for (int i = 0; i < 5; i++) begin
         pops[i] = 0;
         last_pop[i] = -1;
         last_out[i] = '0;
      end
   end

   // Monitor: compare mid-cycle, then predict the handshakes of the next edge.
   always @(negedge clk) begin
      if (stream_mode && !stream_prev) begin
         for (int i = 0; i < 5; i++) last_pop[i] = -1;
      end
      for (int i = 0; i < 5; i++) begin
         int   n;
         logic expv, expr, expb;
         n = 16 >> i;
         if (armed) begin
            expb = (exp_q[i].size() != 0);
            expv = expb && (cyc - acc_q[i][0] >= n);
            expr = !expb || (expv && out_ready);
            chk($sformatf("outValid bpc%0d", 1 << i), 128'(out_valid[i]), 128'(expv));
            chk($sformatf("inReady bpc%0d", 1 << i), 128'(in_ready[i]), 128'(expr));
            chk($sformatf("busy bpc%0d", 1 << i), 128'(busy_o[i]), 128'(expb));
            if (expv) chk($sformatf("stateOut bpc%0d", 1 << i), state_out[i], exp_q[i][0]);
            if (rst_last) chk($sformatf("reset stateOut bpc%0d", 1 << i), state_out[i], 128'h0);
            if (reset) begin
               exp_q[i].delete();
               acc_q[i].delete();
            end else begin
               if (expv && out_ready) begin
                  void'(exp_q[i].pop_front());
                  void'(acc_q[i].pop_front());
                  last_out[i] = state_out[i];
                  pops[i]++;
                  if (stream_mode && last_pop[i] >= 0)
                     chk($sformatf("stream gap bpc%0d", 1 << i), 128'(cyc - last_pop[i]), 128'(n + 1));
                  last_pop[i] = cyc;
               end
               if (expr && in_valid) begin
                  exp_q[i].push_back(ref_sub(state_in));
                  acc_q[i].push_back(cyc + 1);
               end
            end
         end else if (reset) begin
            exp_q[i].delete();
            acc_q[i].delete();
         end
      end
      stream_prev = stream_mode;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [0:127] s);
      in_valid = 1'b1;
      state_in = s;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic wait_idle();
      logic done = 1'b0;
      for (int t = 0; t < 80 && !done; t++) begin
         done = 1'b1;
         for (int i = 0; i < 5; i++) if (exp_q[i].size() != 0) done = 1'b0;
         if (!done) tick();
      end
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL wait_idle: results still pending after 80 cycles");
      end
   endtask

   task automatic chk_all(input string name, input logic [0:127] exp);
      for (int i = 0; i < 5; i++)
         chk($sformatf("%s bpc%0d", name, 1 << i), last_out[i], exp);
   endtask

   logic [0:127] fips_in, fips_out, pat_in, pat_out;

   initial begin
      build_model();
      fips_in  = 128'h7a9f102789d5f50b2beffd9f3dca4ea7;
      fips_out = 128'hbd6e7c3df2b5779e0b61216e8b10b689;
      pat_in   = {8{16'h01ff}};
      pat_out  = {8{16'h097d}};

      // Reset with random inputs for two edges.
      reset = 1'b1;
      for (int r = 0; r < 2; r++) begin
         in_valid  = 1'($urandom);
         out_ready = 1'($urandom);
         state_in  = {$urandom, $urandom, $urandom, $urandom};
         tick();
      end
      reset     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (3) tick();

      // FIPS-197 C.1 round vector.
      send(fips_in);
      wait_idle();
      $display("fips vector: bpc4 out=%h", last_out[2]);
      chk_all("fips", fips_out);

      // Corner bytes.
      send(128'h0);
      wait_idle();
      $display("all 00: bpc4 out=%h", last_out[2]);
      chk_all("all00", {16{8'h52}});
      send({16{8'h63}});
      wait_idle();
      $display("all 63: bpc4 out=%h", last_out[2]);
      chk_all("all63", 128'h0);
      send(pat_in);
      wait_idle();
      $display("01/ff pattern: bpc4 out=%h", last_out[2]);
      chk_all("01ff", pat_out);

      // Back-pressure: result held in DONE while inputs wiggle.
      out_ready = 1'b0;
      send(128'h00112233445566778899aabbccddeeff);
      repeat (20) tick();
      for (int k = 0; k < 10; k++) begin
         in_valid = 1'(k & 1);
         state_in = {$urandom, $urandom, $urandom, $urandom};
         tick();
      end
      in_valid  = 1'b1;
      state_in  = fips_in;
      out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      $display("backpressure release: bpc4 out=%h", last_out[2]);
      chk("backpressure result bpc4", last_out[2], ref_sub(128'h00112233445566778899aabbccddeeff));
      wait_idle();
      $display("after backpressure: bpc4 out=%h", last_out[2]);
      chk_all("bp second", fips_out);

      // Streaming with inValid and outReady held high.
      begin
         int target;
         int t;
         target = pops[2] + 20;
         stream_mode = 1'b1;
         in_valid    = 1'b1;
         for (t = 0; t < 1000 && pops[2] < target; t++) begin
            state_in = {$urandom, $urandom, $urandom, $urandom};
            tick();
         end
         stream_mode = 1'b0;
         in_valid    = 1'b0;
         if (pops[2] < target) begin
            checks++;
            errors++;
            $display("FAIL stream count: got %0d results, expected 20", pops[2] - target + 20);
         end
         $display("streaming: bpc4 results=%0d", pops[2] - target + 20);
      end
      wait_idle();

      // Reset pulse in the middle of RUN.
      send(pat_in);
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      tick();
      send(fips_in);
      wait_idle();
      $display("after mid-run reset: bpc4 out=%h", last_out[2]);
      chk_all("post reset", fips_out);

      repeat (3) tick();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
